// File: rtl/btn_pkg.sv
// Shared types and default 25 MHz timing for the push-button conditioners.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HI,
        HELD,
        REPEAT,
        WAIT_LO
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 500000;
    localparam int DEF_RPT_DELAY   = 12500000;
    localparam int DEF_RPT_PERIOD  = 2500000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for one asynchronous input; chain clears to 0 on reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce_rpt.sv
// Push-button conditioner: synchronise, debounce, press strobe and optional
// auto-repeat strobes while held. All outputs come straight from flops.
module btn_debounce_rpt
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int RPT_EN      = 1,
    parameter int RPT_DELAY   = DEF_RPT_DELAY,
    parameter int RPT_PERIOD  = DEF_RPT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic q,
    output logic db_clk,
    output logic rpt
);

    localparam int TMAX = max3(DB_CYCLES, RPT_DELAY, RPT_PERIOD);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] DB_LAST  = TW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(RPT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(RPT_PERIOD - 1);

    logic          s;
    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          q_nxt, db_nxt, rpt_nxt;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw),
        .q     (s)
    );

    always_comb begin
        state_nxt = state;
        // Saturate rather than wrap so a held button with repeat disabled stays quiet.
        timer_nxt = (&timer) ? timer : timer + TW'(1);
        q_nxt     = q;
        db_nxt    = 1'b0;
        rpt_nxt   = rpt;

        case (state)
            IDLE: begin
                q_nxt     = 1'b0;
                rpt_nxt   = 1'b0;
                timer_nxt = '0;
                if (s) begin
                    state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // A drop of s wins over a coincident debounce expiry.
                if (!s) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (timer == DB_LAST) begin
                    state_nxt = HELD;
                    timer_nxt = '0;
                    q_nxt     = 1'b1;
                    db_nxt    = 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_nxt = WAIT_LO;
                    timer_nxt = '0;
                end else if (RPT_EN != 0 && timer == DLY_LAST) begin
                    state_nxt = REPEAT;
                    timer_nxt = '0;
                    db_nxt    = 1'b1;
                    rpt_nxt   = 1'b1;
                end
            end
            REPEAT: begin
                if (!s) begin
                    state_nxt = WAIT_LO;
                    timer_nxt = '0;
                    rpt_nxt   = 1'b0;
                end else if (timer == PER_LAST) begin
                    timer_nxt = '0;
                    db_nxt    = 1'b1;
                end
            end
            WAIT_LO: begin
                // Bounce on release goes back to HELD silently and restarts the repeat delay.
                if (s) begin
                    state_nxt = HELD;
                    timer_nxt = '0;
                end else if (timer == DB_LAST) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    q_nxt     = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
                q_nxt     = 1'b0;
                rpt_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            timer  <= '0;
            q      <= 1'b0;
            db_clk <= 1'b0;
            rpt    <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            q      <= q_nxt;
            db_clk <= db_nxt;
            rpt    <= rpt_nxt;
        end
    end

endmodule

// File: tb/tb_btn_debounce_rpt.sv
// Bench for btn_debounce_rpt: directed segment table, hand-written corner
// sequences and random raw activity checked against a run-length model.
module tb_btn_debounce_rpt;

    localparam int SS = 2;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic raw = 1'b0;
    logic q1, db1, rpt1;
    logic q0, db0, rpt0;

    always #5 clk = ~clk;

    btn_debounce_rpt #(
        .SYNC_STAGES (SS), .DB_CYCLES (DB), .RPT_EN (1),
        .RPT_DELAY (RD), .RPT_PERIOD (RP)
    ) dut_rpt (
        .clk (clk), .reset (reset), .raw (raw),
        .q (q1), .db_clk (db1), .rpt (rpt1)
    );

    btn_debounce_rpt #(
        .SYNC_STAGES (SS), .DB_CYCLES (DB), .RPT_EN (0),
        .RPT_DELAY (RD), .RPT_PERIOD (RP)
    ) dut_norpt (
        .clk (clk), .reset (reset), .raw (raw),
        .q (q0), .db_clk (db0), .rpt (rpt0)
    );

    // Model: q flips after DB+1 consecutive synced samples disagree with it;
    // h counts consecutive high samples since the press or last release glitch.
    typedef struct {
        logic [SS-1:0] pipe;
        int            run;
        int            h;
        logic          q;
        logic          db;
        logic          rpt;
    } mdl_t;

    typedef struct {
        logic       raw;
        int         len;
        logic [2:0] exp;
    } seg_t;

    mdl_t m1, m0;
    seg_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic mdl_t mstep(input mdl_t m, input logic r, input logic rs, input bit en);
        mdl_t n;
        logic s;
        n = m;
        s = m.pipe[SS-1];
        n.db = 1'b0;
        if (!rs) begin
            n.pipe = '0; n.run = 0; n.h = 0; n.q = 1'b0; n.rpt = 1'b0;
            return n;
        end
        n.pipe = {m.pipe[SS-2:0], r};
        if (!m.q) begin
            n.run = s ? m.run + 1 : 0;
            if (n.run == DB + 1) begin
                n.q = 1'b1; n.db = 1'b1; n.run = 0; n.h = 1;
            end
        end else if (!s) begin
            n.h = 0; n.rpt = 1'b0; n.run = m.run + 1;
            if (n.run == DB + 1) begin
                n.q = 1'b0; n.run = 0;
            end
        end else begin
            n.run = 0; n.h = m.h + 1;
            if (en && n.h >= RD + 1) begin
                n.rpt = 1'b1;
                if ((n.h - RD - 1) % RP == 0) n.db = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got(q,db,rpt)=%b want=%b", nm, $time, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rs);
        raw = r;
        reset = rs;
        @(posedge clk);
        m1 = mstep(m1, r, rs, 1'b1);
        m0 = mstep(m0, r, rs, 1'b0);
        #1;
        check("mdl_rpt", {q1, db1, rpt1}, {m1.q, m1.db, m1.rpt});
        check("mdl_norpt", {q0, db0, rpt0}, {m0.q, m0.db, m0.rpt});
    endtask

    task automatic add(input logic r, input int l, input logic [2:0] e);
        seg_t x;
        x.raw = r; x.len = l; x.exp = e;
        tbl.push_back(x);
    endtask

    initial begin
        int n1, n0, ever_rpt0, lat, len;
        logic v;

        m1 = '{pipe: '0, run: 0, h: 0, q: 1'b0, db: 1'b0, rpt: 1'b0};
        m0 = m1;

        // Clean 40-cycle hold: strobes at 6, 26, 34; release falls at 46.
        add(1, 6, 3'b000); add(1, 1, 3'b110); add(1, 19, 3'b100); add(1, 1, 3'b111);
        add(1, 7, 3'b101); add(1, 1, 3'b111); add(1, 5, 3'b101); add(0, 2, 3'b101);
        add(0, 4, 3'b100); add(0, 1, 3'b000); add(0, 3, 3'b000);
        // Toggle every cycle: nothing accepted.
        for (int i = 0; i < 5; i++) begin
            add(1, 1, 3'b000); add(0, 1, 3'b000);
        end
        add(0, 6, 3'b000);
        // Short pulses: 3 and 4 cycles rejected (4 hits expiry with s dropping), 5 accepted.
        add(1, 3, 3'b000); add(0, 6, 3'b000);
        add(1, 4, 3'b000); add(0, 6, 3'b000);
        add(1, 5, 3'b000); add(0, 1, 3'b000); add(0, 1, 3'b110); add(0, 4, 3'b100);
        add(0, 1, 3'b000); add(0, 3, 3'b000);
        // Release bounce returns to held with repeat delay restarted; final release falls 6 later.
        add(1, 6, 3'b000); add(1, 1, 3'b110); add(1, 3, 3'b100); add(0, 2, 3'b100);
        add(1, 20, 3'b100); add(0, 6, 3'b100); add(0, 1, 3'b000); add(0, 3, 3'b000);

        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("reset", {q1, db1, rpt1}, 3'b000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].len; k++) begin
                step(tbl[i].raw, 1'b1);
                check("tbl", {q1, db1, rpt1}, tbl[i].exp);
            end
        end

        // Long hold: one strobe without repeat, eleven with repeat.
        n1 = 0; n0 = 0; ever_rpt0 = 0;
        for (int i = 0; i < 112; i++) begin
            step((i < 100) ? 1'b1 : 1'b0, 1'b1);
            n1 += int'(db1);
            n0 += int'(db0);
            ever_rpt0 += int'(rpt0);
        end
        check_int("hold_norpt_strobes", n0, 1);
        check_int("hold_norpt_rpt", ever_rpt0, 0);
        check_int("hold_rpt_strobes", n1, 11);
        check("hold_release", {q1, db1, rpt1}, 3'b000);

        // Reset pulse mid-press with raw still high: full debounce again.
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
        check("pre_reset_held", {q1, db1, rpt1}, 3'b100);
        step(1'b1, 1'b0);
        check("reset_abort", {q1, db1, rpt1}, 3'b000);
        check("reset_abort_norpt", {q0, db0, rpt0}, 3'b000);
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            step(1'b1, 1'b1);
            if (db1) lat = i;
        end
        check_int("reset_relatency", lat, 6);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        check("after_relatency", {q1, db1, rpt1}, 3'b000);

        // Random raw runs with occasional resets, checked against the model.
        for (int i = 0; i < 120; i++) begin
            v = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                              : int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) begin
                step(v, ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
